alu_seq: RTL

Multi-cycle sequencer that drives the 16-bit four-function `alu`. It owns an 8×16 register file and accepts commands over a valid/ready handshake. Each command is either a register load or an ALU operation. For an ALU operation, the block reads two source registers, presents them with an op code to the external `alu`, captures the result and carry, writes the result back, and returns it over a valid/ready response channel. It sits between the instruction front-end and the `alu` instance in the datapath.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_reg_file.sv | 30 +++
 rtl/alu_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants, ALU op encodings and sequencer states for alu_seq.
package alu_seq_pkg;
  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;
endpackage

// File: rtl/alu_seq_reg_file.sv
// 8x16 register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
module reg_file
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] ra_addr,
  input  logic [RW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [DW-1:0] wd
);
  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we && (wa != '0)) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem_q[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem_q[rb_addr];
endmodule

// File: rtl/alu_seq.sv
// Command sequencer around an external 16-bit ALU: load/op commands in, one response per command out.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [1:0]    cmd_op,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic [RW-1:0] cmd_rd,
  input  logic [DW-1:0] cmd_imm,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_o,
  input  logic          alu_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_cout,
  output logic          rsp_zero
);
  state_t        state_q, state_d;
  alu_op_t       op_q, op_d, alu_op_q, alu_op_d;
  logic [RW-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DW-1:0] res_q, res_d, rsp_data_q, rsp_data_d;
  logic          cout_q, cout_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d, rsp_zero_q, rsp_zero_d;
  logic [DW-1:0] rf_a, rf_b;

  reg_file u_rf (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (ra_q),
    .rb_addr (rb_q),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (state_q == S_WB),
    .wa      (rd_q),
    .wd      (res_q)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_d       = res_q;
    cout_d      = cout_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_zero_d  = rsp_zero_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d = alu_op_t'(cmd_op);
        ra_d = cmd_ra;
        rb_d = cmd_rb;
        rd_d = cmd_rd;
        if (cmd_ld) begin
          res_d   = cmd_imm;
          cout_d  = 1'b0;
          state_d = S_WB;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        alu_a_d  = rf_a;
        alu_b_d  = rf_b;
        alu_op_d = op_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_o;
        cout_d  = op_q[1] ? 1'b0 : alu_cout;
        state_d = S_WB;
      end
      S_WB: begin
        // Response reports what r[rd] now holds, so r0 writes come back as zero.
        rsp_valid_d = 1'b1;
        rsp_data_d  = (rd_q == '0) ? '0 : res_q;
        rsp_cout_d  = cout_q;
        rsp_zero_d  = (rsp_data_d == '0);
        state_d     = S_RESP;
      end
      S_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      ra_q        <= '0;
      rb_q        <= '0;
      rd_q        <= '0;
      alu_op_q    <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = rsp_zero_q;
endmodule
